// File: rtl/instr_fetch_pkg.sv
// Shared RV32I front-end definitions: fetch FSM states, NOP,
// opcode constants and immediate-type selects used by imm_decoder.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  function automatic imm_sel_e imm_sel_of(input logic [6:0] op);
    imm_sel_e sel;
    sel = IMM_NONE;
    unique case (1'b1)
      (op == OP_LUI) || (op == OP_AUIPC): sel = IMM_U;
      (op == OP_JAL):                     sel = IMM_J;
      (op == OP_BRANCH):                  sel = IMM_B;
      (op == OP_STORE):                   sel = IMM_S;
      (op == OP_JALR) || (op == OP_LOAD)
        || (op == OP_IMM):                sel = IMM_I;
      default:                            sel = IMM_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC, request/ready fetch FSM, instruction
// register and pre-split fields for decode.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7
);

  if_state_e   state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic [31:0] pc_next;
  logic        fire;

  assign tgt     = {redirect_pc[31:2], 2'b00};
  assign pc_next = pc + 32'd4;
  assign fire    = mem_req & mem_ready;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // mem_addr only follows pc while no fetch is in flight, so a
  // redirect during a wait keeps the outstanding address stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= RESET_PC;
    end else begin
      unique case (state)
        S_REQ: begin
          if (redirect_en) begin
            pc <= tgt;
            if (mem_req && !mem_ready) begin
              state <= S_DRAIN;
            end else begin
              mem_addr <= tgt;
              mem_req  <= 1'b1;
            end
          end else if (fire) begin
            instr       <= mem_rdata;
            instr_pc    <= pc;
            pc          <= pc_next;
            mem_addr    <= pc_next;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_VALID;
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_VALID: begin
          if (redirect_en) begin
            pc          <= tgt;
            mem_addr    <= tgt;
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
            state       <= S_REQ;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (redirect_en) begin
            pc <= tgt;
          end
          if (mem_ready) begin
            mem_addr <= redirect_en ? tgt : pc;
            state    <= S_REQ;
          end
        end
        default: begin
          state   <= S_REQ;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multi-cycle RV32I core. Holds the program counter, fetches one 32-bit word per instruction over a simple request/ready memory handshake, and presents the latched instruction and its pre-split fields (including `opcode` for `imm_decoder`) to decode under a valid/ready handshake. Control flow changes arrive as a single-cycle redirect from execute.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_req`  out  1  fetch request, registered.
- `mem_addr`  out  32  word address of the fetch; stable while `mem_req`=1 and `mem_ready`=0.
- `mem_ready`  in  1  memory has `mem_rdata` valid this cycle; sampled only while `mem_req`=1.
- `mem_rdata`  in  32  fetched instruction word.
- `redirect_en`  in  1  one-cycle pulse: branch/jump taken.
- `redirect_pc`  in  32  target PC; bits [1:0] forced to 0 internally.
- `instr_valid`  out  1  `instr` and fields are valid.
- `instr_ready`  in  1  decode consumes the instruction this cycle.
- `instr`  out  32  latched instruction.
- `instr_pc`  out  32  PC of `instr`.
- `opcode` [6:0], `rd` [11:7], `funct3` [14:12], `rs1` [19:15], `rs2` [24:20], `funct7` [31:25]  out  combinational slices of `instr`.

## Operation
- States: `S_REQ` (fetching), `S_VALID` (holding instruction), `S_DRAIN` (outstanding fetch to be discarded).
- Reset values: state `S_REQ` with `mem_req`=0 for the reset cycle, `pc`=`RESET_PC`, `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `instr_pc`=`RESET_PC`. `mem_req` rises on the first clock edge after `reset` deasserts.
- `S_REQ`: `mem_req`=1, `mem_addr`=`pc`. On `mem_ready`: `instr`←`mem_rdata`, `instr_pc`←`pc`, `pc`←`pc`+4 (mod 2^32, wraps 32'hFFFF_FFFC→0), go `S_VALID`.
- `S_VALID`: `mem_req`=0, `instr_valid`=1. On `instr_ready`: go `S_REQ`.
- `S_DRAIN`: `mem_req`=1, `mem_addr` unchanged; on `mem_ready` data dropped, go `S_REQ`.
- Redirect (highest priority, `pc`←`redirect_pc & ~3`):
  - in `S_VALID`: held instruction dropped (`instr_valid`=0 next cycle, even if `instr_ready`=1 same cycle), go `S_REQ`.
  - in `S_REQ` with `mem_ready`=1: returned word dropped, stay `S_REQ`, new address next cycle.
  - in `S_REQ` with `mem_ready`=0: go `S_DRAIN` (memory transactions are never abandoned).
  - in `S_DRAIN`: target overwritten with newest `redirect_pc`; on simultaneous `mem_ready`, go `S_REQ` with newest target.
- Reset mid-transaction: all registers return to reset values immediately; `mem_req` drops asynchronously; memory must tolerate the abandoned request.

## Timing
- All outputs except field slices are registered.
- Zero-wait memory (`mem_ready` in first `mem_req` cycle), decode always ready: request cycle, valid cycle, so one instruction per 2 cycles.
- Fetch latency: `instr_valid` rises the cycle after the `mem_ready` edge.
- Redirect to first request at new PC: 1 cycle (from `S_VALID`/`S_REQ`), or N+1 cycles when N wait cycles remain on the drained fetch.
- `instr`, `instr_pc` and fields remain stable while `instr_valid`=1 and not consumed.

## Structure
- State encodings (`S_REQ`=2'd0, `S_VALID`=2'd1, `S_DRAIN`=2'd2), the NOP constant and RV32I opcode constants go in the shared definitions header next to the immediate-type selects; `imm_decoder` uses the same opcode constants.
- No sub-module: PC register, FSM and instruction register live in one module; field slicing is wiring.

## Test plan
- Reset with `RESET_PC`=32'h100, zero-wait memory, `instr_ready`=1: fetches 0x100, 0x104, 0x108 on alternate cycles; `instr_pc` matches; `opcode`=`mem_rdata`[6:0].
- `mem_ready` delayed 3 cycles: `mem_addr` stays 0x100 and `mem_req` stays 1 for 4 cycles; `instr_valid` rises once.
- `instr_ready`=0 for 5 cycles in `S_VALID`: `instr` held, `mem_req`=0 throughout, next fetch 0x104 only after consumption.
- `redirect_en` with `redirect_pc`=32'h203 during a 2-wait-cycle fetch of 0x104: fetch completes, its data never appears on `instr`, next `mem_addr`=0x200.
- `redirect_en` in `S_VALID` with `instr_ready`=1: `instr_valid`=0 next cycle, next request at target.
- PC 32'hFFFF_FFFC fetched: next `mem_addr`=0; asynchronous `reset` mid-wait: `mem_req`=0 and `instr_valid`=0 before the next clock edge.
